// File: rtl/kv_pkg.sv
// Shared KV-cache types: bank FSM state and the flat
// vector-address builder used by every KV storage reader/writer.
package kv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APP_DONE,
    ST_RD_RUN,
    ST_RD_DRAIN
  } kv_bank_state_t;

  // {is_v, layer, head, time} packed by concatenation; field
  // widths are passed in so any bank geometry can share it.
  function automatic logic [31:0] kv_addr(
    input logic        is_v,
    input logic [31:0] layer,
    input logic [31:0] head,
    input logic [31:0] tm,
    input int          lw,
    input int          hw,
    input int          tw
  );
    logic [31:0] a;
    a = (32'(is_v) << (lw + hw + tw))
      | (layer << (hw + tw))
      | (head << tw)
      | tm;
    return a;
  endfunction

endpackage

// File: rtl/kv_mem_1r1w.sv
// Synchronous 1-write / 1-registered-read memory, no array reset.
// Ports: clk, we/waddr/wdata write port, re/raddr -> rdata next edge.
module kv_mem_1r1w #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/kv_cache_bank.sv
// Dense K/V vector bank: append one vector per transaction, stream
// 1..N time-consecutive vectors per read. Ports: clk/rst, append_*,
// read_req_* request, read_data* stream, busy.
module kv_cache_bank
  import kv_pkg::*;
#(
  parameter int MAX_LAYERS = 4,
  parameter int MAX_HEADS  = 4,
  parameter int MAX_SEQ    = 512,
  parameter int HEAD_DIM   = 16,
  parameter int DW         = 8,
  localparam int LW = $clog2(MAX_LAYERS),
  localparam int HW = $clog2(MAX_HEADS),
  localparam int TW = $clog2(MAX_SEQ),
  localparam int VW = HEAD_DIM * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          append_valid,
  output logic          append_ready,
  input  logic [LW-1:0] append_layer,
  input  logic [HW-1:0] append_head,
  input  logic [TW-1:0] append_time,
  input  logic          append_is_v,
  input  logic [VW-1:0] append_data,
  output logic          append_done,
  input  logic          read_req_valid,
  output logic          read_req_ready,
  input  logic [LW-1:0] read_layer,
  input  logic [HW-1:0] read_head,
  input  logic [TW-1:0] read_time_start,
  input  logic [TW-1:0] read_time_len,
  input  logic          read_is_v,
  output logic          read_data_valid,
  output logic [VW-1:0] read_data,
  output logic          read_data_last,
  output logic          busy
);

  localparam int DEPTH = 2 * MAX_LAYERS * MAX_HEADS * MAX_SEQ;
  localparam int AW    = 1 + LW + HW + TW;

  kv_bank_state_t state_q, state_d;

  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] last_q;
  logic [TW-1:0] start_q;
  logic [LW-1:0] layer_q;
  logic [HW-1:0] head_q;
  logic          is_v_q;
  logic [TW-1:0] rd_tm;

  logic          idle;
  logic          app_acc;
  logic          rd_acc;
  logic          mem_re;
  logic          issue_last;
  logic          iss_v_q;
  logic          iss_last_q;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [VW-1:0] mem_q;

  assign idle = (state_q == ST_IDLE);

  // Append wins a same-cycle collision, so read ready
  // drops while an append is offered.
  assign append_ready   = idle && !rst;
  assign read_req_ready = idle && !rst && !append_valid;
  assign app_acc        = append_valid && append_ready;
  assign rd_acc         = read_req_valid && read_req_ready;

  assign append_done = (state_q == ST_APP_DONE);
  assign busy        = !idle;

  // Time wraps inside the slot range; other fields are fixed.
  assign rd_tm = start_q + cnt_q;

  assign waddr = AW'(kv_addr(append_is_v,
                             32'(append_layer),
                             32'(append_head),
                             32'(append_time),
                             LW, HW, TW));

  assign raddr = AW'(kv_addr(is_v_q,
                             32'(layer_q),
                             32'(head_q),
                             32'(rd_tm),
                             LW, HW, TW));

  kv_mem_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (VW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (app_acc),
    .waddr (waddr),
    .wdata (append_data),
    .re    (mem_re),
    .raddr (raddr),
    .rdata (mem_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_re     = 1'b0;
    issue_last = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (app_acc) begin
          state_d = ST_APP_DONE;
        end else if (rd_acc) begin
          state_d = ST_RD_RUN;
          cnt_d   = '0;
        end
      end
      ST_APP_DONE: begin
        state_d = ST_IDLE;
      end
      ST_RD_RUN: begin
        mem_re     = 1'b1;
        issue_last = (cnt_q == last_q);
        if (issue_last) state_d = ST_RD_DRAIN;
        else            cnt_d   = cnt_q + 1'b1;
      end
      ST_RD_DRAIN: begin
        // Hold until the final vector is on the output so
        // ready returns only the cycle after last.
        if (read_data_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      last_q          <= '0;
      start_q         <= '0;
      layer_q         <= '0;
      head_q          <= '0;
      is_v_q          <= 1'b0;
      iss_v_q         <= 1'b0;
      iss_last_q      <= 1'b0;
      read_data_valid <= 1'b0;
      read_data_last  <= 1'b0;
      read_data       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_acc) begin
        start_q <= read_time_start;
        layer_q <= read_layer;
        head_q  <= read_head;
        is_v_q  <= read_is_v;
        last_q  <= (read_time_len == '0) ? '0
                 : read_time_len - 1'b1;
      end
      iss_v_q         <= mem_re;
      iss_last_q      <= issue_last;
      read_data_valid <= iss_v_q;
      read_data_last  <= iss_last_q;
      if (iss_v_q) read_data <= mem_q;
    end
  end

endmodule

// File: tb/tb_kv_cache_bank.sv
// Scoreboard bench for kv_cache_bank: stimulus pushes expected
// done pulses / stream vectors, a negedge monitor pops and compares.
module tb_kv_cache_bank;

  logic         clk;
  logic         rst;
  logic         append_valid;
  logic         append_ready;
  logic [1:0]   append_layer;
  logic [1:0]   append_head;
  logic [8:0]   append_time;
  logic         append_is_v;
  logic [127:0] append_data;
  logic         append_done;
  logic         read_req_valid;
  logic         read_req_ready;
  logic [1:0]   read_layer;
  logic [1:0]   read_head;
  logic [8:0]   read_time_start;
  logic [8:0]   read_time_len;
  logic         read_is_v;
  logic         read_data_valid;
  logic [127:0] read_data;
  logic         read_data_last;
  logic         busy;

  kv_cache_bank dut (
    .clk             (clk),
    .rst             (rst),
    .append_valid    (append_valid),
    .append_ready    (append_ready),
    .append_layer    (append_layer),
    .append_head     (append_head),
    .append_time     (append_time),
    .append_is_v     (append_is_v),
    .append_data     (append_data),
    .append_done     (append_done),
    .read_req_valid  (read_req_valid),
    .read_req_ready  (read_req_ready),
    .read_layer      (read_layer),
    .read_head       (read_head),
    .read_time_start (read_time_start),
    .read_time_len   (read_time_len),
    .read_is_v       (read_is_v),
    .read_data_valid (read_data_valid),
    .read_data       (read_data),
    .read_data_last  (read_data_last),
    .busy            (busy)
  );

  typedef struct {
    logic [127:0] d;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t         rq[$];
  int           done_q[$];
  logic [127:0] model [logic [13:0]];
  int           cyc;
  int           n_tests;
  int           n_fail;
  logic         mon_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] ta(
    input logic v, input int l, input int h, input int t);
    logic [1:0] l2;
    logic [1:0] h2;
    logic [8:0] t9;
    l2 = 2'(l);
    h2 = 2'(h);
    t9 = 9'(t);
    return {v, l2, h2, t9};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: done pulses and stream vectors against queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (append_done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
        end
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        chk("done_missing", 128'(cyc), 128'(done_q.pop_front()));
      end
      if (read_data_valid) begin
        if (rq.size() == 0) begin
          chk("rd_unexpected", {read_data_last, 1'b1}, 0);
        end else begin
          exp_t e;
          e = rq.pop_front();
          chk("rd_data", read_data, e.d);
          chk("rd_last", read_data_last, e.last);
          chk("rd_cycle", 128'(cyc), 128'(e.cyc));
        end
      end else begin
        if (read_data_last) chk("last_without_valid", 1, 0);
        if (rq.size() != 0 && rq[0].cyc <= cyc) begin
          exp_t e;
          e = rq.pop_front();
          chk("rd_missing", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after accept.
  task automatic do_append(input logic v, input int l, input int h,
                           input int t, input logic [127:0] d);
    int a;
    int k;
    append_is_v  = v;
    append_layer = 2'(l);
    append_head  = 2'(h);
    append_time  = 9'(t);
    append_data  = d;
    append_valid = 1'b1;
    #1;
    k = 0;
    while (!append_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (!append_ready) begin
      chk("app_accept_timeout", 0, 1);
      append_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      a = cyc;
      model[ta(v, l, h, t)] = d;
      done_q.push_back(a);
      @(negedge clk);
      append_valid = 1'b0;
      #1;
      chk("app_rdy_low", append_ready, 0);
    end
  endtask

  // Called at a negedge; returns at the negedge after ready returns.
  task automatic rd_issue(input logic v, input int l, input int h,
                          input int s, input int len,
                          output int acc);
    int   n;
    int   k;
    logic bad;
    exp_t e;
    n = (len == 0) ? 1 : len;
    acc = -1;
    read_is_v       = v;
    read_layer      = 2'(l);
    read_head       = 2'(h);
    read_time_start = 9'(s);
    read_time_len   = 9'(len);
    read_req_valid  = 1'b1;
    #1;
    k = 0;
    while (!read_req_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (!read_req_ready) begin
      chk("rd_accept_timeout", 0, 1);
      read_req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      for (int i = 0; i < n; i++) begin
        e.d    = model[ta(v, l, h, s + i)];
        e.last = (i == n - 1);
        e.cyc  = acc + 2 + i;
        rq.push_back(e);
      end
      @(negedge clk);
      read_req_valid = 1'b0;
      bad = 1'b0;
      for (int j = 0; j <= n + 1; j++) begin
        #1;
        if (read_req_ready) bad = 1'b1;
        @(negedge clk);
      end
      #1;
      chk("rd_rdy_low", bad, 0);
      chk("rd_rdy_back", read_req_ready, 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] d;
    int           a;
    int           acc;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rst     = 1'b1;
    append_valid    = 1'b0;
    append_layer    = '0;
    append_head     = '0;
    append_time     = '0;
    append_is_v     = 1'b0;
    append_data     = '0;
    read_req_valid  = 1'b0;
    read_layer      = '0;
    read_head       = '0;
    read_time_start = '0;
    read_time_len   = '0;
    read_is_v       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_app_rdy", append_ready, 0);
    chk("rst_rd_rdy", read_req_ready, 0);
    chk("rst_done", append_done, 0);
    chk("rst_valid", read_data_valid, 0);
    chk("rst_last", read_data_last, 0);
    chk("rst_data", read_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_app_rdy", append_ready, 1);
    chk("post_rst_rd_rdy", read_req_ready, 1);

    // Single K vector, read back with len=0.
    for (int e = 0; e < 16; e++) d[e*8 +: 8] = 8'(e);
    do_append(1'b0, 1, 2, 5, d);
    rd_issue(1'b0, 1, 2, 5, 0, acc);

    // Four V vectors streamed in order.
    for (int t = 0; t < 4; t++)
      do_append(1'b1, 0, 0, t, {16{8'(8'hA0 + t)}});
    rd_issue(1'b1, 0, 0, 0, 4, acc);

    // Same slot in K and V must not alias.
    do_append(1'b0, 3, 1, 100, {16{8'h55}});
    do_append(1'b1, 3, 1, 100, {16{8'hAA}});
    rd_issue(1'b0, 3, 1, 100, 1, acc);
    rd_issue(1'b1, 3, 1, 100, 1, acc);

    // Append and read offered together.
    append_is_v     = 1'b0;
    append_layer    = 2'd2;
    append_head     = 2'd3;
    append_time     = 9'd7;
    append_data     = {8{16'hBEEF}};
    append_valid    = 1'b1;
    read_is_v       = 1'b0;
    read_layer      = 2'd2;
    read_head       = 2'd3;
    read_time_start = 9'd7;
    read_time_len   = 9'd0;
    read_req_valid  = 1'b1;
    #1;
    chk("both_app_rdy", append_ready, 1);
    chk("both_rd_rdy_low", read_req_ready, 0);
    @(posedge clk); #1;
    a = cyc;
    model[ta(1'b0, 2, 3, 7)] = {8{16'hBEEF}};
    done_q.push_back(a);
    @(negedge clk);
    append_valid = 1'b0;
    rd_issue(1'b0, 2, 3, 7, 0, acc);
    chk("both_rd_accept_cycle", 128'(acc), 128'(a + 2));

    // Time index wraps 510, 511, 0, 1.
    do_append(1'b0, 0, 1, 510, {16{8'h10}});
    do_append(1'b0, 0, 1, 511, {16{8'h11}});
    do_append(1'b0, 0, 1, 0,   {16{8'h12}});
    do_append(1'b0, 0, 1, 1,   {16{8'h13}});
    rd_issue(1'b0, 0, 1, 510, 4, acc);

    // Reset in the middle of an 8-vector stream.
    read_is_v       = 1'b0;
    read_layer      = 2'd0;
    read_head       = 2'd1;
    read_time_start = 9'd510;
    read_time_len   = 9'd8;
    read_req_valid  = 1'b1;
    #1;
    chk("rst_run_rd_rdy", read_req_ready, 1);
    @(posedge clk); #1;
    a = cyc;
    begin
      exp_t e;
      e.d    = {16{8'h10}};
      e.last = 1'b0;
      e.cyc  = a + 2;
      rq.push_back(e);
    end
    @(negedge clk);
    read_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_squash_valid", read_data_valid, 0);
    chk("rst_squash_last", read_data_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_app_rdy", append_ready, 1);
    chk("rel_rd_rdy", read_req_ready, 1);
    chk("rel_busy", busy, 0);
    @(negedge clk);
    rd_issue(1'b0, 1, 2, 5, 0, acc);

    repeat (4) @(negedge clk);
    chk("rq_drained", 128'(rq.size()), 0);
    chk("done_q_drained", 128'(done_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
